// File: rtl/acc_pkg.sv
// acc_pkg: op encodings, output-register states and saturation limits for the accumulator
package acc_pkg;
  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;
endpackage

// File: rtl/add_sub_core.sv
// add_sub_core: combinational ripple add/subtract, B inverted and carry-in set when sub=1
module add_sub_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   c;
  assign bx   = b ^ {WIDTH{sub}};
  assign c[0] = sub;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  assign cout = c[WIDTH];
  // signed overflow: carry into the sign bit disagrees with carry out of it
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/acc_16_bit.sv
// acc_16_bit: registered accumulator with valid/ready handshake, flags and optional saturation
module acc_16_bit
  import acc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_sticky_ovf,
  output logic             out_zero,
  output logic             out_neg
);
  state_t           st, st_n;
  op_t              op;
  logic             accept, arith, ovf_n, carry_n, sticky_n, c_cout, c_ovf;
  logic [WIDTH-1:0] c_sum, res;
  assign op        = op_t'(in_op);
  assign out_valid = st == FULL;
  assign in_ready  = !rst && (st == EMPTY || out_ready);
  assign accept    = in_valid && in_ready;
  // out_data doubles as the accumulator register
  add_sub_core #(.WIDTH(WIDTH)) u_core (
    .a    (out_data),
    .b    (in_data),
    .sub  (op == OP_SUB),
    .sum  (c_sum),
    .cout (c_cout),
    .ovf  (c_ovf)
  );
  // next output-register state and the result/flags of the presented op
  always_comb begin
    st_n     = accept ? FULL : out_ready ? EMPTY : st;
    arith    = op == OP_ADD || op == OP_SUB;
    ovf_n    = arith && c_ovf;
    carry_n  = arith && c_cout;
    res      = op == OP_LOAD  ? in_data :
               op == OP_CLEAR ? '0 :
               (SATURATE && ovf_n) ? (out_data[WIDTH-1] ? WIDTH'(SAT_MIN) : WIDTH'(SAT_MAX)) :
               c_sum;
    sticky_n = op != OP_CLEAR && (out_sticky_ovf || ovf_n);
  end
  // output-register occupancy
  always_ff @(posedge clk) begin
    st <= rst ? EMPTY : st_n;
  end
  // accumulator and flags update only on accept, otherwise hold
  always_ff @(posedge clk) begin
    if (rst)
      {out_data, out_carry, out_ovf, out_sticky_ovf, out_zero, out_neg} <= '0;
    else if (accept)
      {out_data, out_carry, out_ovf, out_sticky_ovf, out_zero, out_neg} <=
        {res, carry_n, ovf_n, sticky_n, res == '0, res[WIDTH-1]};
  end
endmodule
